stp16cpc26_rx: RTL and testbench
================================

# stp16cpc26_rx

Receiving end of the STP16CPC26 serial LED-driver interface: samples `stp16_clk`/`stp16_sdi`/`stp16_le`/`stp16_noe` in the system clock domain and rebuilds the shift-register, output-latch and blanking behaviour of a chain of `width/16` drivers. Serves as an FPGA-side emulator of the LED driver chain and as a bench monitor for the `stp16cpc26` transmitter. Each latched frame is presented on a valid/ready port; the driver-output image is always available.

## Interface
Parameters:
- `width`, 32, total driver outputs in the chain (multiple of 16).
- `sync_stages`, 2, synchronizer flops per input pin (≥2).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stp16_clk`  in  1  serial shift clock from transmitter (asynchronous to `clk`).
- `stp16_sdi`  in  1  serial data.
- `stp16_le`  in  1  latch enable, active high.
- `stp16_noe`  in  1  output enable, active low.
- `data`  out  `width`  last latched frame.
- `led`  out  `width`  emulated driver outputs: `data` when noe low, else 0.
- `o_valid`  out  1  new frame available in `data`.
- `o_ready`  in  1  consumer accepts frame.
- `overrun`  out  1  sticky: frame latched while previous frame unaccepted.
- `frame_err`  out  1  see Configuration.

## Operation
- Each serial input passes through `sync_stages` flops plus one history flop; `stp16_sdi` delayed identically so it stays aligned with `stp16_clk`.
- Rising edge of synchronized `stp16_clk`: `shreg <= {shreg[width-2:0], sdi_s}`. First bit shifted ends at `data[width-1]` after `width` shifts.
- Falling edge of synchronized `stp16_le` = latch event: `data <= shreg` (models transparent latch's final value). Shifts while LE high are legal and included.
- Rising clock edge and LE falling detected in the same cycle: shift applies first; latch captures the post-shift value.
- Output handshake: latch event sets `o_valid`; `o_valid && o_ready` clears it. Latch event with `o_valid` high and `o_ready` low: `data` overwritten, `o_valid` stays 1, `overrun` set. Latch event with `o_valid && o_ready` in same cycle: new data loaded, `o_valid` stays 1, no overrun.
- `led = noe_s ? 0 : data`, registered.
- Reset (any time, including mid-frame): `shreg`=0, `data`=0, `led`=0, `o_valid`=0, `overrun`=0, `frame_err`=0, synchronizer history for `stp16_clk`/`stp16_le` = 0, `stp16_noe` history = 1 (blanked). A partial frame is discarded; no spurious edge on the first cycle after reset.

## Timing
- Pin change sampled at edge N → edge detected and acted on at edge N+`sync_stages`+1 (N+3 default).
- `stp16_clk` high and low phases and `stp16_le` high pulse must each last ≥ `sync_stages`+2 `clk` periods; `stp16_sdi` stable across that window around the rising clock edge. Shorter pulses: behaviour undefined.
- `o_valid` rises one cycle after the latch event is detected; `led` follows `data`/noe with one further register stage.
- `o_ready` is not required before a frame; `o_valid` never drops without acceptance or reset.

## Configuration
- `STP16CPC26_RX_FRAME_CHECK_EN` defined: saturating counter of shifts since the last latch event (width `$clog2(width+1)+1`); at each latch event `frame_err` is set sticky (cleared only by reset) if count ≠ `width`; counter clears on latch event (post-shift count is evaluated).
- Undefined: counter absent, `frame_err` tied 0.

## Structure
- Shared package `stp16_pkg`: default chain width (32), driver width (16), default `sync_stages` (2).
- One sub-module `stp16_input_sync`: parameterised synchronizer + history flop, outputs synchronized level, rise and fall strobes, reset value as parameter; instantiated per input pin.

## Test plan
- Reset then shift 32 bits of 0xA5C3_0F81 MSB-first, pulse LE → `data`=0xA5C3_0F81, `o_valid`=1 three+one cycles after LE falls, `frame_err`=0.
- With `stp16_noe`=1 after above frame → `led`=0; drop noe → `led`=0xA5C3_0F81 within `sync_stages`+2 cycles.
- Hold `o_ready`=0, latch 0x1 then 0x2 → `data`=0x2, `o_valid`=1, `overrun`=1; assert `o_ready` → `o_valid`=0 next cycle, `overrun` stays 1.
- Shift 31 bits then LE (macro defined) → `frame_err`=1; macro undefined → `frame_err`=0.
- Shift 16 bits, assert `reset` for one cycle, shift full 32-bit 0xFFFF_0000 → `data`=0xFFFF_0000, no residue of pre-reset bits.
- Final `stp16_clk` rise coincident with LE fall at detection → latched value includes that last bit.

Source files
------------

// File: rtl/stp16_pkg.sv
// Shared constants for the STP16CPC26 receiver: default chain width,
// per-driver width, default synchronizer depth and the input pin order
// used by the per-pin synchronizer array.
package stp16_pkg;

   localparam int STP16_CHAIN_W     = 32;
   localparam int STP16_DRV_W       = 16;
   localparam int STP16_SYNC_STAGES = 2;

   // Bit positions of the serial pins inside the packed pin vectors.
   typedef enum logic [1:0] {
      PIN_CLK = 2'd0,
      PIN_SDI = 2'd1,
      PIN_LE  = 2'd2,
      PIN_NOE = 2'd3
   } pin_e;

   localparam int NUM_PINS = 4;

   // Number of daisy-chained drivers needed for a given output count.
   function automatic int stp16_num_drivers(input int w);
      return w / STP16_DRV_W;
   endfunction

endpackage

// File: rtl/stp16_input_sync.sv
// Per-pin input conditioning: a `stages`-deep synchronizer, one history
// flop, and registered rise/fall strobes. The level output is the history
// flop so that data pins stay aligned with the strobes of other pins
// instantiated with the same depth.
module stp16_input_sync #(
   parameter int   stages  = 2,
   parameter logic rst_val = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [stages-1:0] sync_q;
   logic              hist_q;

   // Synchronize the pin, keep one sample of history and register edge strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= {stages{rst_val}};
         hist_q <= rst_val;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[stages-2:0], din};
         hist_q <= sync_q[stages-1];
         rise   <= sync_q[stages-1] & ~hist_q;
         fall   <= ~sync_q[stages-1] & hist_q;
      end
   end

   assign level = hist_q;

endmodule

// File: rtl/stp16cpc26_rx.sv
// STP16CPC26 receiver / driver-chain emulator. Rebuilds the shift register,
// output latch and blanking of a width/16 driver chain from the serial pins
// sampled in the clk domain, and presents each latched frame on a
// valid/ready port.
// Optional feature: define STP16CPC26_RX_FRAME_CHECK_EN to flag latch events
// that do not follow exactly `width` shifts (sticky frame_err).
module stp16cpc26_rx
   import stp16_pkg::*;
#(
   parameter int width       = STP16_CHAIN_W,
   parameter int sync_stages = STP16_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stp16_clk,
   input  logic             stp16_sdi,
   input  logic             stp16_le,
   input  logic             stp16_noe,
   output logic [width-1:0] data,
   output logic [width-1:0] led,
   output logic             o_valid,
   input  logic             o_ready,
   output logic             overrun,
   output logic             frame_err
);

   logic [NUM_PINS-1:0] pin_raw, pin_lvl, pin_rise, pin_fall;
   logic                shift_ev, latch_ev, sdi_s, noe_s;
   logic [width-1:0]    shreg, shreg_nxt;

   assign pin_raw = {stp16_noe, stp16_le, stp16_sdi, stp16_clk};

   // noe idles blanked (1) out of reset; every other pin idles low so no
   // edge is seen right after reset.
   for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
      stp16_input_sync #(
         .stages  (sync_stages),
         .rst_val ((g == int'(PIN_NOE)) ? 1'b1 : 1'b0)
      ) u_sync (
         .clk   (clk),
         .reset (reset),
         .din   (pin_raw[g]),
         .level (pin_lvl[g]),
         .rise  (pin_rise[g]),
         .fall  (pin_fall[g])
      );
   end

   assign shift_ev = pin_rise[PIN_CLK];
   assign latch_ev = pin_fall[PIN_LE];
   assign sdi_s    = pin_lvl[PIN_SDI];
   assign noe_s    = pin_lvl[PIN_NOE];

   // Strobes/levels this block has no use for.
   logic unused_pins;
   assign unused_pins = ^{pin_rise[PIN_SDI], pin_rise[PIN_LE], pin_rise[PIN_NOE],
                          pin_fall[PIN_CLK], pin_fall[PIN_SDI], pin_fall[PIN_NOE],
                          pin_lvl[PIN_CLK], pin_lvl[PIN_LE]};

   // Post-shift register value; a latch in the same cycle captures this.
   always_comb begin
      shreg_nxt = shreg;
      if (shift_ev) shreg_nxt = {shreg[width-2:0], sdi_s};
   end

   // Shift register, output latch, handshake and blanked LED image.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg   <= '0;
         data    <= '0;
         led     <= '0;
         o_valid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         shreg <= shreg_nxt;
         led   <= noe_s ? '0 : data;
         if (latch_ev) begin
            data    <= shreg_nxt;
            o_valid <= 1'b1;
            if (o_valid && !o_ready) overrun <= 1'b1;
         end else if (o_valid && o_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

`ifdef STP16CPC26_RX_FRAME_CHECK_EN
   localparam int CW = $clog2(width + 1) + 1;

   logic [CW-1:0] shift_cnt, cnt_nxt;

   // Saturating shift count including a shift coincident with the latch.
   always_comb begin
      cnt_nxt = shift_cnt;
      if (shift_ev && (shift_cnt != {CW{1'b1}})) cnt_nxt = shift_cnt + 1'b1;
   end

   // Check frame length at each latch event; error is sticky until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_cnt <= '0;
         frame_err <= 1'b0;
      end else if (latch_ev) begin
         shift_cnt <= '0;
         if (cnt_nxt != CW'(width)) frame_err <= 1'b1;
      end else begin
         shift_cnt <= cnt_nxt;
      end
   end
`else
   assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_stp16cpc26_rx.sv
// Self-checking bench for stp16cpc26_rx: drives the serial pins with legal
// pulse widths and compares against a frame-level model of the driver chain.
module tb_stp16cpc26_rx;

   localparam int W  = 32;
   localparam int SS = 2;
   localparam int P  = SS + 2;  // minimum phase length on the serial pins

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          stp16_clk = 1'b0, stp16_sdi = 1'b0, stp16_le = 1'b0, stp16_noe = 1'b1;
   logic          o_ready = 1'b0;
   logic [W-1:0]  data, led;
   logic          o_valid, overrun, frame_err;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [W-1:0] shreg_m = '0, data_m = '0;
   logic         valid_m = 1'b0, ovr_m = 1'b0, err_m = 1'b0, noe_m = 1'b1;
   int           cnt_m = 0;

   stp16cpc26_rx #(.width(W), .sync_stages(SS)) dut (
      .clk(clk), .reset(reset),
      .stp16_clk(stp16_clk), .stp16_sdi(stp16_sdi), .stp16_le(stp16_le), .stp16_noe(stp16_noe),
      .data(data), .led(led), .o_valid(o_valid), .o_ready(o_ready),
      .overrun(overrun), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      shreg_m = '0; data_m = '0; valid_m = 0; ovr_m = 0; err_m = 0; cnt_m = 0;
   endtask

   task automatic model_latch();
      if (valid_m && !o_ready) ovr_m = 1'b1;
      data_m  = shreg_m;
      valid_m = 1'b1;
`ifdef STP16CPC26_RX_FRAME_CHECK_EN
      if (cnt_m != W) err_m = 1'b1;
`endif
      cnt_m = 0;
   endtask

   task automatic ser_bit(input logic b);
      stp16_sdi = b;
      repeat (P) tick();
      stp16_clk = 1'b1;
      shreg_m = {shreg_m[W-2:0], b};
      cnt_m++;
      repeat (P) tick();
      stp16_clk = 1'b0;
   endtask

   task automatic shift_word(input logic [W-1:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) ser_bit(v[i]);
   endtask

   task automatic latch_pulse();
      stp16_le = 1'b1;
      repeat (P) tick();
      stp16_le = 1'b0;
      model_latch();
      repeat (6) tick();
   endtask

   task automatic accept();
      o_ready = 1'b1;
      tick();
      o_ready = 1'b0;
      valid_m = 1'b0;
      checks++;
      if (o_valid !== 1'b0) begin
         errors++; $display("FAIL accept_valid got %0b want 0", o_valid);
      end
      checks++;
      if (overrun !== ovr_m) begin
         errors++; $display("FAIL accept_overrun got %0b want %0b", overrun, ovr_m);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      model_reset();
      checks++;
      if ({data, led, o_valid, overrun, frame_err} !== '0) begin
         errors++;
         $display("FAIL reset_state got data=%h led=%h v=%b ovr=%b ferr=%b want all 0",
                  data, led, o_valid, overrun, frame_err);
      end
      reset = 1'b0;
      repeat (4) tick();
      checks++;
      if (o_valid !== 1'b0 || data !== '0) begin
         errors++; $display("FAIL reset_idle got v=%b data=%h want 0/0", o_valid, data);
      end
   endtask

   task automatic test_frame();
      logic [W-1:0] v;
      v = 32'hA5C3_0F81;
      shift_word(v, W);
      stp16_le = 1'b1;
      repeat (P) tick();
      stp16_le = 1'b0;
      model_latch();
      repeat (3) tick();
      checks++;
      if (o_valid !== 1'b0) begin
         errors++; $display("FAIL frame_early_valid got %0b want 0", o_valid);
      end
      tick();
      checks++;
      if (o_valid !== 1'b1) begin
         errors++; $display("FAIL frame_valid_latency got %0b want 1", o_valid);
      end
      checks++;
      if (data !== v) begin
         errors++; $display("FAIL frame_data got %h want %h", data, v);
      end
      checks++;
      if (frame_err !== 1'b0) begin
         errors++; $display("FAIL frame_err_clean got %0b want 0", frame_err);
      end
      repeat (2) tick();
   endtask

   task automatic test_blank();
      int n;
      checks++;
      if (led !== '0) begin
         errors++; $display("FAIL blank_led got %h want 0", led);
      end
      stp16_noe = 1'b0;
      noe_m = 1'b0;
      n = 0;
      while (led !== data_m && n < SS + 2) begin
         tick();
         n++;
      end
      checks++;
      if (led !== data_m) begin
         errors++; $display("FAIL unblank_led got %h want %h after %0d cycles", led, data_m, n);
      end
      accept();
   endtask

   task automatic test_overrun();
      shift_word(32'h1, W);
      latch_pulse();
      checks++;
      if (overrun !== 1'b0 || o_valid !== 1'b1) begin
         errors++; $display("FAIL overrun_first got ovr=%b v=%b want 0/1", overrun, o_valid);
      end
      shift_word(32'h2, W);
      latch_pulse();
      checks++;
      if (data !== 32'h2) begin
         errors++; $display("FAIL overrun_data got %h want 00000002", data);
      end
      checks++;
      if (o_valid !== 1'b1 || overrun !== 1'b1) begin
         errors++; $display("FAIL overrun_flags got v=%b ovr=%b want 1/1", o_valid, overrun);
      end
      accept();
   endtask

   task automatic test_frame_err();
      logic [W-1:0] v;
      v = $urandom;
      shift_word(v, W - 1);
      latch_pulse();
      checks++;
      if (data !== data_m) begin
         errors++; $display("FAIL short_data got %h want %h", data, data_m);
      end
      checks++;
      if (frame_err !== err_m) begin
         errors++; $display("FAIL short_frame_err got %0b want %0b", frame_err, err_m);
      end
      accept();
   endtask

   task automatic test_reset_midframe();
      logic [W-1:0] v;
      v = $urandom;
      shift_word(v, 16);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      checks++;
      if (data !== '0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
         errors++; $display("FAIL midreset_state got data=%h ferr=%b ovr=%b want 0", data, frame_err, overrun);
      end
      repeat (4) tick();
      shift_word(32'hFFFF_0000, W);
      latch_pulse();
      checks++;
      if (data !== 32'hFFFF_0000) begin
         errors++; $display("FAIL midreset_data got %h want ffff0000", data);
      end
      checks++;
      if (frame_err !== 1'b0) begin
         errors++; $display("FAIL midreset_frame_err got %0b want 0", frame_err);
      end
      checks++;
      if (led !== data_m) begin
         errors++; $display("FAIL midreset_led got %h want %h", led, data_m);
      end
      accept();
   endtask

   task automatic test_coincident();
      logic [W-1:0] v;
      v = $urandom;
      v[0] = ~data_m[0];
      stp16_le = 1'b1;
      repeat (P) tick();
      shift_word(v >> 1, W - 1);
      stp16_sdi = v[0];
      repeat (P) tick();
      stp16_clk = 1'b1;
      stp16_le  = 1'b0;
      shreg_m = {shreg_m[W-2:0], v[0]};
      cnt_m++;
      model_latch();
      repeat (P) tick();
      stp16_clk = 1'b0;
      repeat (4) tick();
      checks++;
      if (data !== v) begin
         errors++; $display("FAIL coincident_data got %h want %h", data, v);
      end
      checks++;
      if (frame_err !== err_m) begin
         errors++; $display("FAIL coincident_frame_err got %0b want %0b", frame_err, err_m);
      end
      accept();
   endtask

   task automatic test_random();
      logic [W-1:0] v;
      for (int k = 0; k < 4; k++) begin
         v = $urandom;
         stp16_noe = $urandom_range(0, 1);
         noe_m = stp16_noe;
         shift_word(v, W);
         latch_pulse();
         checks++;
         if (data !== data_m || data_m !== v) begin
            errors++; $display("FAIL rand_data[%0d] got %h want %h", k, data, v);
         end
         checks++;
         if (led !== (noe_m ? '0 : data_m)) begin
            errors++; $display("FAIL rand_led[%0d] got %h want %h", k, led, noe_m ? '0 : data_m);
         end
         checks++;
         if (o_valid !== valid_m || overrun !== ovr_m || frame_err !== err_m) begin
            errors++;
            $display("FAIL rand_flags[%0d] got v=%b ovr=%b ferr=%b want %b/%b/%b",
                     k, o_valid, overrun, frame_err, valid_m, ovr_m, err_m);
         end
         accept();
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_blank();
      test_overrun();
      test_frame_err();
      test_reset_midframe();
      test_coincident();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
